// File: rtl/mem_responder_pkg.sv
// Shared types and constants for the wait-state memory responder.
package mem_responder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam int unsigned DEF_DEPTH_WORDS = 256;
    localparam int unsigned DEF_WAIT_CYCLES = 2;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned WORD_W = 32;
    localparam int unsigned BE_W   = 4;
    localparam int unsigned CNT_W  = 4;

    // A fault is a misaligned byte address or a word index beyond the store.
    function automatic logic addr_fault(input logic [ADDR_W-1:0] addr,
                                        input int unsigned       depth);
        return (addr[1:0] != 2'b00) || ({2'b00, addr[ADDR_W-1:2]} >= depth);
    endfunction

endpackage

// File: rtl/mem_responder_mem_array.sv
// Single-port synchronous word RAM with byte enables; contents are never reset.
module mem_array #(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          en_i,
    input  logic          we_i,
    input  logic [3:0]    be_i,
    input  logic [AW-1:0] idx_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [DEPTH];

    // Read data is only refreshed by an enabled load, so it holds otherwise.
    always_ff @(posedge clk_i) begin
        if (en_i) begin
            if (we_i) begin
                for (int i = 0; i < 4; i++) begin
                    if (be_i[i]) mem_q[idx_i][8*i +: 8] <= wdata_i[8*i +: 8];
                end
            end else begin
                rdata_o <= mem_q[idx_i];
            end
        end
    end

endmodule

// File: rtl/mem_responder.sv
// CPU-facing memory responder: accepts one request, waits WAIT_CYCLES, performs the access, holds the response.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = DEF_DEPTH_WORDS,
    parameter int unsigned WAIT_CYCLES = DEF_WAIT_CYCLES
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [WORD_W-1:0] req_wdata,
    input  logic [BE_W-1:0]   req_be,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [WORD_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              busy
);

    localparam int unsigned AW        = $clog2(DEPTH_WORDS);
    localparam logic        ZERO_WAIT = (WAIT_CYCLES == 0);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               write_q, err_q, load_q;
    logic [AW-1:0]      idx_q;
    logic [WORD_W-1:0]  wdata_q;
    logic [BE_W-1:0]    be_q;

    logic               accept, req_err, wait_done;
    logic               access, op_write, op_err, ram_en;
    logic [AW-1:0]      op_idx;
    logic [WORD_W-1:0]  op_wdata, ram_rdata;
    logic [BE_W-1:0]    op_be;

    assign req_err   = addr_fault(req_addr, DEPTH_WORDS);
    assign accept    = req_valid && (state_q == ST_IDLE);
    assign wait_done = (state_q == ST_WAIT) && (cnt_q <= CNT_W'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    cnt_d   = CNT_W'(WAIT_CYCLES);
                    state_d = ZERO_WAIT ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (wait_done) state_d = ST_RESP;
            end
            ST_RESP: begin
                if (resp_ready) state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Request fields are captured only on accept; requests seen while busy never touch them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            write_q <= 1'b0;
            err_q   <= 1'b0;
            load_q  <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            be_q    <= '0;
        end else if (accept) begin
            write_q <= req_write;
            err_q   <= req_err;
            load_q  <= !req_write && !req_err;
            idx_q   <= req_addr[AW+1:2];
            wdata_q <= req_wdata;
            be_q    <= req_be;
        end
    end

    // With no wait states the RAM sees the live request on the accept edge.
    always_comb begin
        if (ZERO_WAIT) begin
            access   = accept;
            op_write = req_write;
            op_err   = req_err;
            op_idx   = req_addr[AW+1:2];
            op_wdata = req_wdata;
            op_be    = req_be;
        end else begin
            access   = wait_done;
            op_write = write_q;
            op_err   = err_q;
            op_idx   = idx_q;
            op_wdata = wdata_q;
            op_be    = be_q;
        end
    end

    assign ram_en = access && !op_err && !rst;

    mem_array #(
        .DEPTH (DEPTH_WORDS),
        .AW    (AW)
    ) u_mem (
        .clk_i   (clk),
        .en_i    (ram_en),
        .we_i    (op_write),
        .be_i    (op_be),
        .idx_i   (op_idx),
        .wdata_i (op_wdata),
        .rdata_o (ram_rdata)
    );

    assign req_ready  = (state_q == ST_IDLE);
    assign busy       = (state_q != ST_IDLE);
    assign resp_valid = (state_q == ST_RESP);
    assign resp_err   = resp_valid && err_q;
    assign resp_rdata = (resp_valid && load_q) ? ram_rdata : '0;

endmodule

// File: tb/tb_mem_responder.sv
// Directed scoreboard bench for mem_responder: a WAIT_CYCLES=2 instance and a zero-wait instance.
module tb_mem_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sel = 1'b0;
    logic        req_valid = 1'b0, req_write = 1'b0, resp_ready = 1'b0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic [3:0]  req_be = '0;

    logic        a_req_ready, a_resp_valid, a_resp_err, a_busy;
    logic        z_req_ready, z_resp_valid, z_resp_err, z_busy;
    logic [31:0] a_resp_rdata, z_resp_rdata;
    logic        req_ready, resp_valid, resp_err, busy;
    logic [31:0] resp_rdata;

    assign req_ready  = sel ? z_req_ready  : a_req_ready;
    assign resp_valid = sel ? z_resp_valid : a_resp_valid;
    assign resp_err   = sel ? z_resp_err   : a_resp_err;
    assign resp_rdata = sel ? z_resp_rdata : a_resp_rdata;
    assign busy       = sel ? z_busy       : a_busy;

    always #5 clk = ~clk;

    mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(2)) dut_a (
        .clk(clk), .rst(rst),
        .req_valid(req_valid && !sel), .req_ready(a_req_ready),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .resp_valid(a_resp_valid), .resp_ready(resp_ready && !sel),
        .resp_rdata(a_resp_rdata), .resp_err(a_resp_err), .busy(a_busy)
    );

    mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) dut_z (
        .clk(clk), .rst(rst),
        .req_valid(req_valid && sel), .req_ready(z_req_ready),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .resp_valid(z_resp_valid), .resp_ready(resp_ready && sel),
        .resp_rdata(z_resp_rdata), .resp_err(z_resp_err), .busy(z_busy)
    );

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } resp_t;

    resp_t       sb[$];
    logic [31:0] model [2][256];
    int          checks = 0;
    int          failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Reference behaviour: updates the bench's own memory image and yields the response.
    task automatic predict(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] be, output resp_t r);
        r = '0;
        if (a[1:0] != 2'b00 || a[31:2] >= 30'd256) begin
            r.err = 1'b1;
        end else if (w) begin
            for (int i = 0; i < 4; i++)
                if (be[i]) model[sel][a[9:2]][8*i +: 8] = d[8*i +: 8];
        end else begin
            r.rdata = model[sel][a[9:2]];
        end
    endtask

    task automatic do_req(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] be, input int hold, input string tag);
        resp_t exp_r, pred;
        int    lat;
        logic [31:0] first_rdata;
        logic        first_err;
        @(negedge clk);
        chk({tag, ":ready_idle"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; req_be = be;
        @(posedge clk); #1;
        // Scramble the bus right after accept so only latched fields can be used.
        req_valid = 1'b0; req_addr = 32'h0000_0004; req_wdata = 32'h0BAD_0BAD; req_be = 4'hF;
        predict(w, a, d, be, pred);
        sb.push_back(pred);
        lat = 1;
        while (!resp_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, ":latency"}, 32'(lat), sel ? 32'd1 : 32'd3);
        chk({tag, ":busy"}, 32'(busy), 32'd1);
        exp_r = sb.pop_front();
        chk({tag, ":rdata"}, resp_rdata, exp_r.rdata);
        chk({tag, ":err"}, 32'(resp_err), 32'(exp_r.err));
        first_rdata = resp_rdata;
        first_err   = resp_err;
        for (int i = 0; i < hold; i++) begin
            req_valid = (i % 2 == 0); req_write = 1'b1; req_addr = 32'h10;
            req_wdata = 32'hFFFF_FFFF; req_be = 4'hF;
            @(posedge clk); #1;
            chk({tag, ":hold_valid"}, 32'(resp_valid), 32'd1);
            chk({tag, ":hold_rdata"}, resp_rdata, first_rdata);
            chk({tag, ":hold_err"}, 32'(resp_err), 32'(first_err));
            chk({tag, ":hold_req_ready"}, 32'(req_ready), 32'd0);
        end
        req_valid = 1'b0;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        chk({tag, ":released"}, 32'(resp_valid), 32'd0);
        chk({tag, ":back_idle"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        int seen;
        int idx;
        logic [31:0] a;

        repeat (3) @(negedge clk);
        chk("rst:req_ready", 32'(req_ready), 32'd1);
        chk("rst:resp_valid", 32'(resp_valid), 32'd0);
        chk("rst:rdata", resp_rdata, 32'd0);
        chk("rst:err", 32'(resp_err), 32'd0);
        chk("rst:busy", 32'(busy), 32'd0);
        rst = 1'b0;

        do_req(1'b1, 32'h10, 32'hDEADBEEF, 4'b1111, 0, "st_full");
        do_req(1'b0, 32'h10, 32'h0, 4'h0, 0, "ld_full");
        do_req(1'b1, 32'h10, 32'h11223344, 4'b0101, 0, "st_part");
        do_req(1'b0, 32'h10, 32'h0, 4'h0, 0, "ld_part");
        do_req(1'b0, 32'h12, 32'h0, 4'h0, 0, "ld_misalign");
        do_req(1'b0, 32'h400, 32'h0, 4'h0, 0, "ld_range");
        do_req(1'b1, 32'h0, 32'hA5A5A5A5, 4'hF, 0, "st_w0");
        do_req(1'b1, 32'h400, 32'hFFFFFFFF, 4'hF, 0, "st_range");
        do_req(1'b0, 32'h0, 32'h0, 4'h0, 0, "ld_w0");
        do_req(1'b1, 32'h10, 32'h99999999, 4'b0000, 0, "st_be0");
        do_req(1'b0, 32'h10, 32'h0, 4'h0, 5, "ld_hold");
        do_req(1'b0, 32'h10, 32'h0, 4'h0, 0, "ld_after_hold");

        // Reset while a store sits in WAIT must drop it.
        do_req(1'b1, 32'h20, 32'h01020304, 4'hF, 0, "st_prior");
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h20;
        req_wdata = 32'hCAFEF00D; req_be = 4'hF;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("abort:in_wait", 32'(busy), 32'd1);
        rst = 1'b1; #1;
        chk("abort:busy", 32'(busy), 32'd0);
        chk("abort:req_ready", 32'(req_ready), 32'd1);
        chk("abort:resp_valid", 32'(resp_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (resp_valid) seen++;
        end
        chk("abort:no_resp", 32'(seen), 32'd0);
        do_req(1'b0, 32'h20, 32'h0, 4'h0, 0, "abort:ld_prior");

        for (int k = 0; k < 8; k++)
            do_req(1'b1, 32'((64 + k) * 4), $urandom, 4'hF, 0, "rnd_fill");
        for (int k = 0; k < 16; k++) begin
            idx = 64 + $urandom_range(0, 7);
            a   = 32'(idx * 4) | (($urandom_range(0, 7) == 0) ? 32'd2 : 32'd0);
            do_req(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)), 0, "rnd");
        end

        // Zero-wait instance.
        sel = 1'b1;
        do_req(1'b1, 32'h10, 32'h13579BDF, 4'hF, 0, "z_st");
        do_req(1'b0, 32'h10, 32'h0, 4'h0, 0, "z_ld");
        do_req(1'b1, 32'h10, 32'hAAAA5555, 4'b0011, 0, "z_st_part");
        do_req(1'b0, 32'h10, 32'h0, 4'h0, 2, "z_ld_part");
        do_req(1'b0, 32'h401, 32'h0, 4'h0, 0, "z_ld_err");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 256, number of 32-bit words in the data store (power of two).
REQ-002 Parameter WAIT_CYCLES, default 2, wait states inserted before each access (0..15).
REQ-003 clk  input  1  clock; all state updates on posedge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 req_valid  input  1  CPU request present.
REQ-006 req_ready  output  1  responder accepts the request this cycle.
REQ-007 req_write  input  1  1 = store, 0 = load.
REQ-008 req_addr  input  32  byte address.
REQ-009 req_wdata  input  32  store data.
REQ-010 req_be  input  4  byte enables for the store; bit i enables wdata[8i+7:8i].
REQ-011 resp_valid  output  1  response present.
REQ-012 resp_ready  input  1  CPU consumes the response.
REQ-013 resp_rdata  output  32  load data; 0 for stores and errors.
REQ-014 resp_err  output  1  access faulted (misaligned or out of range).
REQ-015 busy  output  1  FSM not in IDLE.

Function
REQ-016 FSM states SHALL be IDLE, WAIT, RESP.
REQ-017 req_ready SHALL be 1 only in IDLE; resp_valid SHALL be 1 only in RESP.
REQ-018 Accept = req_valid & req_ready at posedge; write, addr, wdata and be SHALL be latched, the wait counter SHALL load WAIT_CYCLES, and the FSM SHALL enter WAIT (or RESP directly when WAIT_CYCLES = 0).
REQ-019 In WAIT the counter SHALL decrement each cycle; on the cycle it reaches 0 the access SHALL be performed and the FSM SHALL enter RESP.
REQ-020 Latency from the accept edge to resp_valid high SHALL be exactly WAIT_CYCLES+1 cycles.
REQ-021 Error SHALL be flagged when addr[1:0] != 0 or the word index addr[31:2] >= DEPTH_WORDS.
REQ-022 On error no memory write SHALL occur, resp_err SHALL be 1 and resp_rdata SHALL be 0.
REQ-023 A valid store SHALL update only the enabled bytes; req_be = 0000 SHALL be a no-op that still responds with resp_err = 0.
REQ-024 A valid load SHALL return the full word at addr[31:2]; a store SHALL return resp_rdata = 0.
REQ-025 resp_rdata and resp_err SHALL hold stable while resp_valid = 1 and resp_ready = 0.
REQ-026 resp_valid & resp_ready at posedge SHALL return the FSM to IDLE; the next request is accepted no earlier than the following cycle (no back-to-back overlap).
REQ-027 req_valid asserted outside IDLE SHALL be ignored and SHALL NOT be latched.
REQ-028 A load immediately after a store to the same word SHALL return the updated data.

Reset
REQ-029 While rst = 1: FSM = IDLE, counter = 0, req_ready = 1, resp_valid = 0, resp_rdata = 0, resp_err = 0, busy = 0.
REQ-030 Reset in WAIT or RESP SHALL abort the transaction with no response and no memory write; a store not yet performed SHALL be dropped.
REQ-031 Memory contents SHALL NOT be cleared by reset.

Structure
REQ-032 A shared package SHALL hold the state enum, default DEPTH_WORDS/WAIT_CYCLES constants, and the error-check helper width constants.
REQ-033 One sub-module mem_array (single-port synchronous RAM, 32-bit, 4 byte-enables, DEPTH_WORDS deep) SHALL hold the storage; FSM, counter and response registers stay in mem_responder.

Verification
REQ-034 Store addr 0x10, wdata 0xDEADBEEF, be 1111; then load 0x10 -> resp_rdata 0xDEADBEEF, resp_err 0, each response 3 cycles after its accept (WAIT_CYCLES = 2).
REQ-035 Store 0x10 wdata 0x11223344 be 0101 over 0xDEADBEEF; load 0x10 -> 0xDE22BE44.
REQ-036 Load addr 0x12 -> resp_err 1, rdata 0; load addr 0x400 (DEPTH 256) -> resp_err 1; a store to 0x400 leaves word 0 unchanged.
REQ-037 Hold resp_ready 0 for 5 cycles in RESP -> resp_valid, rdata and err stable and req_ready 0; pulsing req_valid meanwhile is ignored.
REQ-038 Assert rst in WAIT during a store of 0xCAFEF00D to 0x20 -> IDLE next cycle, no response; subsequent load 0x20 returns the prior value.
REQ-039 WAIT_CYCLES = 0 build: accept at cycle n -> resp_valid at cycle n+1.
